// File: rtl/decode_stage.sv
// Registered MIPS decode stage: one instruction per cycle into a control bundle,
// with valid/ready handshakes on both sides and load-use hazard stalling.
module decode_stage #(
    parameter int unsigned SB_DEPTH    = 3,
    parameter int unsigned LOAD_SHADOW = 1,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             w_clk,
    input  logic             w_rst_n,
    input  logic             w_flush,
    input  logic             w_in_valid,
    input  logic [31:0]      w_in_instr_32,
    output logic             w_in_ready,
    output logic             w_out_valid,
    input  logic             w_out_ready,
    output logic [31:0]      w_out_instr_32,
    output logic [10:0]      w_out_ctrl_11,
    output logic [5:0]       w_out_op_type_6,
    output logic [4:0]       w_out_dest_5,
    output logic [CNT_W-1:0] w_stall_cnt
);

    localparam int unsigned C_ALU   = 10;
    localparam int unsigned C_UNS   = 9;
    localparam int unsigned C_IMM   = 8;
    localparam int unsigned C_BYTE  = 7;
    localparam int unsigned C_SHIFT = 6;
    localparam int unsigned C_MEM   = 5;
    localparam int unsigned C_WRITE = 4;
    localparam int unsigned C_BR    = 3;
    localparam int unsigned C_JUMP  = 2;
    localparam int unsigned C_RJUMP = 1;
    localparam int unsigned C_NOP   = 0;

    logic [5:0]  opc, func;
    logic [4:0]  rs, rt, rd, shamt;
    logic [10:0] dec_ctrl;
    logic [5:0]  dec_op;
    logic [4:0]  dec_dest;
    logic        dec_nop, dec_load, use_rs, use_rt;

    logic [SB_DEPTH-1:0] sb_valid, sb_load;
    logic [4:0]          sb_dest [SB_DEPTH];
    logic                hazard, in_fire, advance;

    assign opc   = w_in_instr_32[31:26];
    assign rs    = w_in_instr_32[25:21];
    assign rt    = w_in_instr_32[20:16];
    assign rd    = w_in_instr_32[15:11];
    assign shamt = w_in_instr_32[10:6];
    assign func  = w_in_instr_32[5:0];

    always_comb begin
        dec_ctrl = '0;
        dec_op   = opc;
        dec_dest = '0;
        dec_nop  = 1'b0;
        dec_load = 1'b0;
        use_rs   = 1'b0;
        use_rt   = 1'b0;
        case (opc)
            6'h00: begin
                dec_op = func;
                case (func)
                    6'h08: begin dec_ctrl[C_JUMP] = 1'b1; dec_ctrl[C_RJUMP] = 1'b1; use_rs = 1'b1; end
                    6'h09: begin
                        dec_ctrl[C_JUMP] = 1'b1; dec_ctrl[C_RJUMP] = 1'b1; use_rs = 1'b1; dec_dest = rd;
                    end
                    6'h21, 6'h23, 6'h2B: begin
                        dec_ctrl[C_ALU] = 1'b1; dec_ctrl[C_UNS] = 1'b1;
                        use_rs = 1'b1; use_rt = 1'b1; dec_dest = rd;
                    end
                    // MULT/DIV results land in HI/LO, so no GPR destination
                    6'h19, 6'h1B: begin
                        dec_ctrl[C_ALU] = 1'b1; dec_ctrl[C_UNS] = 1'b1; use_rs = 1'b1; use_rt = 1'b1;
                    end
                    6'h18, 6'h1A: begin dec_ctrl[C_ALU] = 1'b1; use_rs = 1'b1; use_rt = 1'b1; end
                    6'h20, 6'h22, 6'h2A, 6'h24, 6'h25, 6'h26, 6'h27: begin
                        dec_ctrl[C_ALU] = 1'b1; use_rs = 1'b1; use_rt = 1'b1; dec_dest = rd;
                    end
                    6'h10, 6'h12: begin dec_ctrl[C_ALU] = 1'b1; dec_dest = rd; end
                    6'h00, 6'h02, 6'h03: begin
                        if (func == 6'h00 && shamt == 5'd0) begin
                            dec_nop = 1'b1;
                        end else begin
                            dec_ctrl[C_ALU] = 1'b1; dec_ctrl[C_IMM] = 1'b1; dec_ctrl[C_SHIFT] = 1'b1;
                            use_rt = 1'b1; dec_dest = rd;
                        end
                    end
                    6'h04, 6'h06, 6'h07: begin
                        dec_ctrl[C_ALU] = 1'b1; dec_ctrl[C_SHIFT] = 1'b1;
                        use_rs = 1'b1; use_rt = 1'b1; dec_dest = rd;
                    end
                    6'h34:   begin use_rs = 1'b1; use_rt = 1'b1; end
                    default: dec_nop = 1'b1;
                endcase
            end
            6'h01: begin
                if (rt == 5'd0 || rt == 5'd1) begin
                    dec_ctrl[C_BR] = 1'b1; use_rs = 1'b1; dec_op = {1'b0, rt};
                end else begin
                    dec_nop = 1'b1;
                end
            end
            6'h02, 6'h03: begin
                dec_ctrl[C_JUMP] = 1'b1; dec_ctrl[C_IMM] = 1'b1; dec_ctrl[C_RJUMP] = 1'b1;
                if (opc == 6'h03) dec_dest = 5'd31;
            end
            6'h04, 6'h05: begin dec_ctrl[C_BR] = 1'b1; use_rs = 1'b1; use_rt = 1'b1; end
            6'h06, 6'h07: begin dec_ctrl[C_BR] = 1'b1; use_rs = 1'b1; end
            6'h09, 6'h0B: begin
                dec_ctrl[C_ALU] = 1'b1; dec_ctrl[C_IMM] = 1'b1; dec_ctrl[C_UNS] = 1'b1;
                use_rs = 1'b1; dec_dest = rt;
            end
            6'h0A, 6'h0C, 6'h0D, 6'h0E: begin
                dec_ctrl[C_ALU] = 1'b1; dec_ctrl[C_IMM] = 1'b1; use_rs = 1'b1; dec_dest = rt;
            end
            6'h1C: begin dec_ctrl[C_ALU] = 1'b1; use_rs = 1'b1; use_rt = 1'b1; dec_dest = rd; end
            6'h0F: begin dec_ctrl[C_MEM] = 1'b1; dec_ctrl[C_IMM] = 1'b1; dec_dest = rt; end
            6'h20, 6'h23, 6'h24: begin
                dec_ctrl[C_MEM]  = 1'b1;
                dec_ctrl[C_BYTE] = (opc != 6'h23);
                dec_ctrl[C_UNS]  = (opc == 6'h24);
                use_rs = 1'b1; dec_dest = rt; dec_load = 1'b1;
            end
            6'h28, 6'h2B: begin
                dec_ctrl[C_MEM] = 1'b1; dec_ctrl[C_WRITE] = 1'b1;
                dec_ctrl[C_BYTE] = (opc == 6'h28);
                use_rs = 1'b1; use_rt = 1'b1;
            end
            default: dec_nop = 1'b1;
        endcase
        if (dec_nop) begin
            dec_ctrl = '0;
            dec_ctrl[C_NOP] = 1'b1;
            dec_op   = '0;
            dec_dest = '0;
            dec_load = 1'b0;
            use_rs   = 1'b0;
            use_rt   = 1'b0;
        end
    end

    always_comb begin
        hazard = 1'b0;
        for (int unsigned i = 0; i < LOAD_SHADOW; i++) begin
            if (sb_valid[i] && sb_load[i] && sb_dest[i] != 5'd0 &&
                ((use_rs && rs == sb_dest[i]) || (use_rt && rt == sb_dest[i])))
                hazard = 1'b1;
        end
    end

    assign advance    = ~w_out_valid | w_out_ready;
    assign w_in_ready = w_rst_n & advance & ~hazard & ~w_flush;
    assign in_fire    = w_in_valid & w_in_ready;

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            w_out_valid     <= 1'b0;
            w_out_instr_32  <= '0;
            w_out_ctrl_11   <= '0;
            w_out_op_type_6 <= '0;
            w_out_dest_5    <= '0;
            w_stall_cnt     <= '0;
            sb_valid        <= '0;
            sb_load         <= '0;
            for (int unsigned i = 0; i < SB_DEPTH; i++) sb_dest[i] <= '0;
        end else begin
            if (w_in_valid && hazard && !w_flush && !(&w_stall_cnt))
                w_stall_cnt <= w_stall_cnt + CNT_W'(1);
            if (w_flush) begin
                w_out_valid <= 1'b0;
                sb_valid    <= '0;
            end else begin
                if (in_fire) begin
                    w_out_valid     <= 1'b1;
                    w_out_instr_32  <= w_in_instr_32;
                    w_out_ctrl_11   <= dec_ctrl;
                    w_out_op_type_6 <= dec_op;
                    w_out_dest_5    <= dec_dest;
                end else if (w_out_ready) begin
                    w_out_valid <= 1'b0;
                end
                // Scoreboard tracks the output register plus older in-flight writers
                if (advance) begin
                    for (int unsigned i = 1; i < SB_DEPTH; i++) begin
                        sb_valid[i] <= sb_valid[i-1];
                        sb_load[i]  <= sb_load[i-1];
                        sb_dest[i]  <= sb_dest[i-1];
                    end
                    sb_valid[0] <= in_fire;
                    sb_load[0]  <= in_fire & dec_load;
                    sb_dest[0]  <= in_fire ? dec_dest : 5'd0;
                end
            end
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage (stall counter narrowed to 4 bits).
module tb_decode_stage;

    localparam logic [10:0] ALU = 11'h400, UNS = 11'h200, IMM = 11'h100, BYT = 11'h080;
    localparam logic [10:0] SHF = 11'h040, MEM = 11'h020, WRT = 11'h010, BRN = 11'h008;
    localparam logic [10:0] JMP = 11'h004, RJ = 11'h002, NOP = 11'h001;

    logic        w_clk = 1'b0;
    logic        w_rst_n, w_flush, w_in_valid, w_in_ready, w_out_valid, w_out_ready;
    logic [31:0] w_in_instr_32, w_out_instr_32;
    logic [10:0] w_out_ctrl_11;
    logic [5:0]  w_out_op_type_6;
    logic [4:0]  w_out_dest_5;
    logic [3:0]  w_stall_cnt;

    int total = 0;
    int bad   = 0;

    decode_stage #(.SB_DEPTH(3), .LOAD_SHADOW(1), .CNT_W(4)) dut (
        .w_clk(w_clk), .w_rst_n(w_rst_n), .w_flush(w_flush),
        .w_in_valid(w_in_valid), .w_in_instr_32(w_in_instr_32), .w_in_ready(w_in_ready),
        .w_out_valid(w_out_valid), .w_out_ready(w_out_ready),
        .w_out_instr_32(w_out_instr_32), .w_out_ctrl_11(w_out_ctrl_11),
        .w_out_op_type_6(w_out_op_type_6), .w_out_dest_5(w_out_dest_5),
        .w_stall_cnt(w_stall_cnt)
    );

    always #5 w_clk = ~w_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge w_clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr);
        w_in_valid    = 1'b1;
        w_in_instr_32 = instr;
        #1;
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd, sh, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt,
                                          input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    typedef struct {
        logic [31:0] instr;
        logic [10:0] ctrl;
        logic [5:0]  op;
        logic [4:0]  dest;
    } vec_t;

    vec_t vecs[$];
    logic [31:0] held;

    initial begin
        w_rst_n = 1'b0; w_flush = 1'b0; w_in_valid = 1'b0; w_in_instr_32 = '0; w_out_ready = 1'b1;
        step(); step();
        chk("rst_valid", 32'(w_out_valid), 0);
        chk("rst_ready", 32'(w_in_ready), 0);
        chk("rst_instr", w_out_instr_32, 0);
        chk("rst_ctrl", 32'(w_out_ctrl_11), 0);
        chk("rst_op", 32'(w_out_op_type_6), 0);
        chk("rst_dest", 32'(w_out_dest_5), 0);
        chk("rst_cnt", 32'(w_stall_cnt), 0);
        w_rst_n = 1'b1;
        #1;

        // ADDU r3,r1,r2
        drive(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h21));
        chk("t1_ready", 32'(w_in_ready), 1);
        step(); w_in_valid = 1'b0;
        chk("t1_valid", 32'(w_out_valid), 1);
        chk("t1_ctrl", 32'(w_out_ctrl_11), 32'(ALU | UNS));
        chk("t1_op", 32'(w_out_op_type_6), 32'h21);
        chk("t1_dest", 32'(w_out_dest_5), 3);
        chk("t1_instr", w_out_instr_32, rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h21));
        step();
        chk("t1_drain", 32'(w_out_valid), 0);

        // Load-use: LW r5 then ADD r6,r5,r2
        drive(itype(6'h23, 5'd1, 5'd5, 16'd0));
        step();
        drive(rtype(5'd5, 5'd2, 5'd6, 5'd0, 6'h20));
        chk("t2_lw_ctrl", 32'(w_out_ctrl_11), 32'(MEM));
        chk("t2_lw_dest", 32'(w_out_dest_5), 5);
        chk("t2_stall_ready", 32'(w_in_ready), 0);
        step();
        chk("t2_cnt", 32'(w_stall_cnt), 1);
        chk("t2_bubble", 32'(w_out_valid), 0);
        chk("t2_ready_again", 32'(w_in_ready), 1);
        step(); w_in_valid = 1'b0;
        chk("t2_add_valid", 32'(w_out_valid), 1);
        chk("t2_add_ctrl", 32'(w_out_ctrl_11), 32'(ALU));
        chk("t2_add_dest", 32'(w_out_dest_5), 6);

        // LW r0 then use of r0; LW r5 then J
        drive(itype(6'h23, 5'd1, 5'd0, 16'd4));
        step();
        drive(rtype(5'd0, 5'd0, 5'd7, 5'd0, 6'h21));
        chk("t3_r0_ready", 32'(w_in_ready), 1);
        step();
        chk("t3_r0_dest", 32'(w_out_dest_5), 7);
        drive(itype(6'h23, 5'd1, 5'd5, 16'd0));
        step();
        drive({6'h02, 26'h10});
        chk("t3_j_ready", 32'(w_in_ready), 1);
        step(); w_in_valid = 1'b0;
        chk("t3_j_ctrl", 32'(w_out_ctrl_11), 32'(JMP | IMM | RJ));
        chk("t3_j_op", 32'(w_out_op_type_6), 2);
        chk("t3_cnt", 32'(w_stall_cnt), 1);

        // Back-pressure hold, then release
        held = itype(6'h0D, 5'd1, 5'd8, 16'h55);
        drive(held);
        step();
        w_out_ready = 1'b0;
        drive(itype(6'h0E, 5'd1, 5'd9, 16'h3));
        for (int i = 0; i < 4; i++) begin
            chk("t4_hold_ready", 32'(w_in_ready), 0);
            chk("t4_hold_valid", 32'(w_out_valid), 1);
            chk("t4_hold_instr", w_out_instr_32, held);
            step();
        end
        w_out_ready = 1'b1;
        #1;
        chk("t4_rel_ready", 32'(w_in_ready), 1);
        step(); w_in_valid = 1'b0;
        chk("t4_next_instr", w_out_instr_32, itype(6'h0E, 5'd1, 5'd9, 16'h3));
        chk("t4_next_ctrl", 32'(w_out_ctrl_11), 32'(ALU | IMM));
        chk("t4_next_dest", 32'(w_out_dest_5), 9);
        step();
        chk("t4_no_dup", 32'(w_out_valid), 0);

        // Flush with a load held in the output register
        drive(itype(6'h23, 5'd1, 5'd10, 16'd0));
        step();
        w_out_ready = 1'b0;
        w_flush = 1'b1;
        drive(itype(6'h04, 5'd1, 5'd2, 16'd4));
        chk("t5_flush_ready", 32'(w_in_ready), 0);
        step();
        w_flush = 1'b0;
        chk("t5_flush_valid", 32'(w_out_valid), 0);
        w_out_ready = 1'b1;
        drive(rtype(5'd10, 5'd2, 5'd11, 5'd0, 6'h20));
        chk("t5_sb_clear", 32'(w_in_ready), 1);
        step(); w_in_valid = 1'b0;
        chk("t5_add_dest", 32'(w_out_dest_5), 11);
        chk("t5_cnt_kept", 32'(w_stall_cnt), 1);

        // Decode table
        vecs.push_back('{rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h00), NOP, 6'h00, 5'd0});
        vecs.push_back('{rtype(5'd0, 5'd2, 5'd3, 5'd4, 6'h00), ALU | IMM | SHF, 6'h00, 5'd3});
        vecs.push_back('{{6'h3F, 26'h123}, NOP, 6'h00, 5'd0});
        vecs.push_back('{{6'h01, 5'd1, 5'd5, 16'd8}, NOP, 6'h00, 5'd0});
        vecs.push_back('{{6'h01, 5'd1, 5'd1, 16'd8}, BRN, 6'h01, 5'd0});
        vecs.push_back('{{6'h03, 26'h40}, JMP | IMM | RJ, 6'h03, 5'd31});
        vecs.push_back('{itype(6'h28, 5'd2, 5'd4, 16'd1), MEM | WRT | BYT, 6'h28, 5'd0});
        vecs.push_back('{itype(6'h24, 5'd2, 5'd6, 16'd0), MEM | BYT | UNS, 6'h24, 5'd6});
        vecs.push_back('{rtype(5'd1, 5'd2, 5'd0, 5'd0, 6'h34), 11'h000, 6'h34, 5'd0});
        vecs.push_back('{itype(6'h0B, 5'd1, 5'd7, 16'd5), ALU | IMM | UNS, 6'h0B, 5'd7});
        vecs.push_back('{rtype(5'd31, 5'd0, 5'd0, 5'd0, 6'h08), JMP | RJ, 6'h08, 5'd0});
        vecs.push_back('{rtype(5'd1, 5'd2, 5'd9, 5'd0, 6'h07), ALU | SHF, 6'h07, 5'd9});
        foreach (vecs[k]) begin
            drive(vecs[k].instr);
            chk($sformatf("dec%0d_ready", k), 32'(w_in_ready), 1);
            step(); w_in_valid = 1'b0;
            chk($sformatf("dec%0d_ctrl", k), 32'(w_out_ctrl_11), 32'(vecs[k].ctrl));
            chk($sformatf("dec%0d_op", k), 32'(w_out_op_type_6), 32'(vecs[k].op));
            chk($sformatf("dec%0d_dest", k), 32'(w_out_dest_5), 32'(vecs[k].dest));
        end

        // Saturate the stall counter with a held load
        drive(itype(6'h23, 5'd1, 5'd12, 16'd0));
        step();
        w_out_ready = 1'b0;
        drive(rtype(5'd12, 5'd0, 5'd13, 5'd0, 6'h21));
        for (int i = 0; i < 5; i++) step();
        chk("sat_mid", 32'(w_stall_cnt), 6);
        for (int i = 0; i < 15; i++) step();
        chk("sat_max", 32'(w_stall_cnt), 15);
        chk("sat_ready", 32'(w_in_ready), 0);
        w_out_ready = 1'b1;
        step(); step(); w_in_valid = 1'b0;
        chk("sat_add_dest", 32'(w_out_dest_5), 13);
        chk("sat_hold", 32'(w_stall_cnt), 15);

        // Asynchronous reset while a bundle is held
        drive(itype(6'h0D, 5'd1, 5'd14, 16'd1));
        step(); w_in_valid = 1'b0;
        w_out_ready = 1'b0;
        #2;
        w_rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(w_out_valid), 0);
        chk("arst_dest", 32'(w_out_dest_5), 0);
        chk("arst_cnt", 32'(w_stall_cnt), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
